// File: rtl/psum_accumulator_pkg.sv
// Shared types and elaboration-time helpers for the partial-sum accumulator.
// The accumulator width and saturation limits are derived here so every file agrees on them.
package psum_accumulator_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACCUM = 2'd1,
    DRAIN = 2'd2
  } state_t;

  localparam int LIMIT_WIDTH = 128;

  // Headroom for MAX_PASSES sums plus the bias, so the running total never wraps.
  function automatic int acc_width(input int sum_w, input int max_passes);
    return sum_w + $clog2(max_passes) + 1;
  endfunction

  function automatic logic signed [LIMIT_WIDTH-1:0] sat_limit(input int out_w,
                                                              input logic want_max);
    logic signed [LIMIT_WIDTH-1:0] w_one;
    w_one = {{(LIMIT_WIDTH-1){1'b0}}, 1'b1};
    if (want_max) begin
      return (w_one <<< (out_w - 1)) - w_one;
    end
    return -(w_one <<< (out_w - 1));
  endfunction

endpackage

// File: rtl/psum_accumulator_output_requant.sv
// Round-shift requantisation, optional ReLU and signed saturation of a finished accumulation.
// Purely combinational; the caller registers the result.
module output_requant
  import psum_accumulator_pkg::*;
#(
  parameter int IN_WIDTH  = 45,
  parameter int OUT_WIDTH = 32
) (
  input  logic signed [IN_WIDTH-1:0]  value,
  input  logic        [4:0]           shift,
  input  logic                        relu,
  output logic signed [OUT_WIDTH-1:0] result,
  output logic                        sat
);

  localparam logic signed [IN_WIDTH:0] ONE   = {{IN_WIDTH{1'b0}}, 1'b1};
  localparam logic signed [IN_WIDTH:0] MAX_V = (IN_WIDTH+1)'(sat_limit(OUT_WIDTH, 1'b1));
  localparam logic signed [IN_WIDTH:0] MIN_V = (IN_WIDTH+1)'(sat_limit(OUT_WIDTH, 1'b0));

  logic signed [IN_WIDTH:0] w_value_ext;
  logic signed [IN_WIDTH:0] w_half;
  logic signed [IN_WIDTH:0] w_sum;
  logic signed [IN_WIDTH:0] w_shifted;
  logic signed [IN_WIDTH:0] w_relu;

  // One guard bit keeps the rounding add from wrapping at the extreme positive value.
  assign w_value_ext = {value[IN_WIDTH-1], value};
  assign w_half      = (ONE <<< shift) >>> 1;
  assign w_sum       = w_value_ext + w_half;
  assign w_shifted   = w_sum >>> shift;
  assign w_relu      = (relu && w_shifted[IN_WIDTH]) ? '0 : w_shifted;

  // NOTE: every output gets a default first, so no path through the block can infer a latch.
  always_comb begin
    result = w_relu[OUT_WIDTH-1:0];
    sat    = 1'b0;
    if (w_relu > MAX_V) begin
      result = MAX_V[OUT_WIDTH-1:0];
      sat    = 1'b1;
    end else if (w_relu < MIN_V) begin
      result = MIN_V[OUT_WIDTH-1:0];
      sat    = 1'b1;
    end
  end

endmodule

// File: rtl/psum_accumulator.sv
// Accumulates a configurable number of adder-tree partial sums on top of a per-pixel bias,
// requantises the total and hands one result per pixel to the output buffer.
module psum_accumulator
  import psum_accumulator_pkg::*;
#(
  parameter int SUM_WIDTH  = 38,
  parameter int OUT_WIDTH  = 32,
  parameter int MAX_PASSES = 64
) (
  input  logic                                clk,
  input  logic                                arst_in,
  input  logic [$clog2(MAX_PASSES+1)-1:0]     cfg_num_passes,
  input  logic [4:0]                          cfg_shift,
  input  logic                                cfg_relu,
  input  logic signed [OUT_WIDTH-1:0]         bias_in,
  input  logic                                in_valid,
  output logic                                in_ready,
  input  logic signed [SUM_WIDTH-1:0]         in_sum,
  output logic                                out_valid,
  input  logic                                out_ready,
  output logic signed [OUT_WIDTH-1:0]         out_data,
  output logic                                out_sat,
  output logic                                busy
);

  localparam int ACC_WIDTH = acc_width(SUM_WIDTH, MAX_PASSES);
  localparam int PASS_W    = $clog2(MAX_PASSES + 1);
  localparam logic [PASS_W-1:0] PASS_ONE = PASS_W'(1);
  localparam logic [PASS_W-1:0] PASS_MAX = PASS_W'(MAX_PASSES);

  state_t                       r_state;
  logic signed [ACC_WIDTH-1:0]  r_acc;
  logic        [PASS_W-1:0]     r_cnt;
  logic        [PASS_W-1:0]     r_passes;
  logic        [4:0]            r_shift;
  logic                         r_relu;
  logic signed [OUT_WIDTH-1:0]  r_out_data;
  logic                         r_out_sat;

  logic                         w_first;
  logic                         w_beat;
  logic                         w_out_hs;
  logic                         w_last;
  logic        [PASS_W-1:0]     w_cfg_passes;
  logic        [PASS_W-1:0]     w_passes;
  logic        [4:0]            w_shift;
  logic                         w_relu;
  logic        [PASS_W-1:0]     w_cnt_next;
  logic signed [ACC_WIDTH-1:0]  w_sum_ext;
  logic signed [ACC_WIDTH-1:0]  w_bias_ext;
  logic signed [ACC_WIDTH-1:0]  w_acc_next;
  logic signed [OUT_WIDTH-1:0]  w_result;
  logic                         w_sat;

  assign out_valid = (r_state == DRAIN);
  assign busy      = (r_state != IDLE);
  assign out_data  = r_out_data;
  assign out_sat   = r_out_sat;
  assign in_ready  = !arst_in && ((r_state == DRAIN) ? out_ready : 1'b1);

  assign w_beat   = in_valid && in_ready;
  assign w_out_hs = out_valid && out_ready;

  // Any beat outside ACCUM opens a new pixel, so it sees the live configuration, not the latched one.
  assign w_first      = (r_state != ACCUM);
  assign w_cfg_passes = (cfg_num_passes == '0)      ? PASS_ONE :
                        (cfg_num_passes > PASS_MAX) ? PASS_MAX : cfg_num_passes;
  assign w_passes     = w_first ? w_cfg_passes : r_passes;
  assign w_shift      = w_first ? cfg_shift    : r_shift;
  assign w_relu       = w_first ? cfg_relu     : r_relu;

  assign w_sum_ext  = {{(ACC_WIDTH-SUM_WIDTH){in_sum[SUM_WIDTH-1]}}, in_sum};
  assign w_bias_ext = {{(ACC_WIDTH-OUT_WIDTH){bias_in[OUT_WIDTH-1]}}, bias_in};
  assign w_acc_next = w_first ? (w_bias_ext + w_sum_ext) : (r_acc + w_sum_ext);
  assign w_cnt_next = w_first ? PASS_ONE : (r_cnt + PASS_ONE);
  assign w_last     = (w_cnt_next == w_passes);

  output_requant #(
    .IN_WIDTH  (ACC_WIDTH),
    .OUT_WIDTH (OUT_WIDTH)
  ) u_requant (
    .value  (w_acc_next),
    .shift  (w_shift),
    .relu   (w_relu),
    .result (w_result),
    .sat    (w_sat)
  );

  // NOTE: state is updated with non-blocking assignments so every register sees pre-edge values.
  always_ff @(posedge clk or posedge arst_in) begin
    if (arst_in) begin
      r_state    <= IDLE;
      r_acc      <= '0;
      r_cnt      <= '0;
      r_passes   <= PASS_ONE;
      r_shift    <= '0;
      r_relu     <= 1'b0;
      r_out_data <= '0;
      r_out_sat  <= 1'b0;
    end else begin
      if (w_beat) begin
        r_acc <= w_acc_next;
        r_cnt <= w_cnt_next;
        if (w_first) begin
          r_passes <= w_cfg_passes;
          r_shift  <= cfg_shift;
          r_relu   <= cfg_relu;
        end
        if (w_last) begin
          r_state    <= DRAIN;
          r_out_data <= w_result;
          r_out_sat  <= w_sat;
        end else begin
          r_state <= ACCUM;
        end
      end else if (w_out_hs) begin
        r_state <= IDLE;
      end
    end
  end

endmodule

// File: tb/tb_psum_accumulator.sv
// Self-checking bench: directed vector table, stall/back-to-back/reset sequences and a
// randomized run checked against an arithmetic model of the requantised pixel sum.
module tb_psum_accumulator;

  localparam int SUM_WIDTH  = 38;
  localparam int OUT_WIDTH  = 32;
  localparam int MAX_PASSES = 64;
  localparam longint MAXV = 64'sd2147483647;
  localparam longint MINV = -64'sd2147483648;

  logic                         clk = 1'b0;
  logic                         arst_in;
  logic [6:0]                   cfg_num_passes;
  logic [4:0]                   cfg_shift;
  logic                         cfg_relu;
  logic signed [OUT_WIDTH-1:0]  bias_in;
  logic                         in_valid;
  logic                         in_ready;
  logic signed [SUM_WIDTH-1:0]  in_sum;
  logic                         out_valid;
  logic                         out_ready;
  logic signed [OUT_WIDTH-1:0]  out_data;
  logic                         out_sat;
  logic                         busy;

  int n_total = 0;
  int n_pass  = 0;

  psum_accumulator #(
    .SUM_WIDTH  (SUM_WIDTH),
    .OUT_WIDTH  (OUT_WIDTH),
    .MAX_PASSES (MAX_PASSES)
  ) dut (
    .clk            (clk),
    .arst_in        (arst_in),
    .cfg_num_passes (cfg_num_passes),
    .cfg_shift      (cfg_shift),
    .cfg_relu       (cfg_relu),
    .bias_in        (bias_in),
    .in_valid       (in_valid),
    .in_ready       (in_ready),
    .in_sum         (in_sum),
    .out_valid      (out_valid),
    .out_ready      (out_ready),
    .out_data       (out_data),
    .out_sat        (out_sat),
    .busy           (busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    int     passes;
    int     nbeats;
    longint bias;
    int     shift;
    bit     relu;
    longint sums[4];
    longint exp_data;
    bit     exp_sat;
  } vec_t;

  task automatic check(input string name, input longint act, input longint exp);
    n_total++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d", name, act, exp);
  endtask

  // Requantisation straight from the arithmetic definition, on 64-bit integers.
  function automatic void model(input longint v, input int shift, input bit relu,
                                output longint r, output bit sat);
    longint t;
    t = (shift > 0) ? v + (longint'(1) <<< (shift - 1)) : v;
    t = t >>> shift;
    if (relu && t < 0) t = 0;
    sat = 1'b0;
    if (t > MAXV) begin t = MAXV; sat = 1'b1; end
    else if (t < MINV) begin t = MINV; sat = 1'b1; end
    r = t;
  endfunction

  task automatic do_beat(input longint sum);
    int waited;
    waited = 0;
    in_valid = 1'b1;
    in_sum   = sum[SUM_WIDTH-1:0];
    @(negedge clk);
    while (!in_ready && waited < 200) begin
      @(negedge clk);
      waited++;
    end
    if (!in_ready) check("beat_timeout", 0, 1);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  task automatic set_cfg(input int passes, input longint bias, input int shift, input bit relu);
    cfg_num_passes = 7'(passes);
    bias_in        = bias[OUT_WIDTH-1:0];
    cfg_shift      = 5'(shift);
    cfg_relu       = relu;
  endtask

  vec_t   vecs[9];
  longint s[8];

  initial begin
    arst_in = 1'b1;
    in_valid = 1'b0;
    in_sum = '0;
    out_ready = 1'b1;
    set_cfg(1, 0, 0, 0);

    repeat (2) @(posedge clk);
    #1;
    check("rst_in_ready", in_ready, 0);
    check("rst_out_valid", out_valid, 0);
    check("rst_out_data", out_data, 0);
    check("rst_out_sat", out_sat, 0);
    check("rst_busy", busy, 0);
    arst_in = 1'b0;
    @(posedge clk);
    #1;
    check("idle_in_ready", in_ready, 1);

    vecs[0] = '{3, 3, 10, 0, 0, '{100, 200, -50, 0}, 260, 0};
    vecs[1] = '{1, 1, 0, 2, 0, '{7, 0, 0, 0}, 2, 0};
    vecs[2] = '{1, 1, 0, 2, 0, '{-7, 0, 0, 0}, -2, 0};
    vecs[3] = '{2, 2, 0, 0, 1, '{-100, -1, 0, 0}, 0, 0};
    vecs[4] = '{2, 2, 0, 0, 0, '{-100, -1, 0, 0}, -101, 0};
    vecs[5] = '{2, 2, 0, 0, 0, '{64'sd68719476736, 64'sd68719476736, 0, 0}, MAXV, 1};
    vecs[6] = '{2, 2, 0, 0, 0, '{-64'sd68719476736, -64'sd68719476736, 0, 0}, MINV, 1};
    vecs[7] = '{0, 1, 3, 0, 0, '{5, 0, 0, 0}, 8, 0};
    vecs[8] = '{1, 1, 0, 31, 0, '{64'sd6442450944, 0, 0, 0}, 3, 0};

    foreach (vecs[v]) begin
      set_cfg(vecs[v].passes, vecs[v].bias, vecs[v].shift, vecs[v].relu);
      for (int i = 0; i < vecs[v].nbeats; i++) begin
        if (i == vecs[v].nbeats - 1) check($sformatf("v%0d_pre_valid", v), out_valid, 0);
        do_beat(vecs[v].sums[i]);
      end
      check($sformatf("v%0d_valid", v), out_valid, 1);
      check($sformatf("v%0d_data", v), out_data, vecs[v].exp_data);
      check($sformatf("v%0d_sat", v), out_sat, vecs[v].exp_sat);
      @(posedge clk);
      #1;
      check($sformatf("v%0d_drained", v), out_valid, 0);
    end

    // Stall in DRAIN, then release into back-to-back single-pass pixels.
    out_ready = 1'b0;
    set_cfg(2, 0, 0, 0);
    do_beat(1);
    do_beat(2);
    for (int k = 0; k < 8; k++) s[k] = longint'($signed($urandom_range(0, 2000000))) - 1000000;
    set_cfg(1, 0, 0, 0);
    in_valid = 1'b1;
    in_sum   = s[0][SUM_WIDTH-1:0];
    repeat (5) begin
      @(negedge clk);
      check("stall_valid", out_valid, 1);
      check("stall_data", out_data, 3);
      check("stall_in_ready", in_ready, 0);
    end
    out_ready = 1'b1;
    for (int k = 0; k < 8; k++) begin
      @(posedge clk);
      #1;
      if (k < 7) in_sum = s[k+1][SUM_WIDTH-1:0];
      else in_valid = 1'b0;
      @(negedge clk);
      check($sformatf("b2b%0d_valid", k), out_valid, 1);
      check($sformatf("b2b%0d_data", k), out_data, s[k]);
    end
    @(posedge clk);
    #1;
    check("b2b_drained", out_valid, 0);

    // Reset in the middle of a pixel drops it entirely.
    set_cfg(4, 1000, 0, 0);
    do_beat(11);
    do_beat(22);
    arst_in = 1'b1;
    #1;
    check("mid_rst_in_ready", in_ready, 0);
    check("mid_rst_busy", busy, 0);
    @(posedge clk);
    #1;
    arst_in = 1'b0;
    repeat (3) begin
      @(posedge clk);
      #1;
      check("post_rst_no_valid", out_valid, 0);
    end
    set_cfg(1, 0, 0, 0);
    do_beat(5);
    check("post_rst_valid", out_valid, 1);
    check("post_rst_data", out_data, 5);
    @(posedge clk);
    #1;

    // Randomized pixels with bubbles and configuration noise on non-first beats.
    for (int p = 0; p < 40; p++) begin
      int     cfg_p, eff_p, sh;
      bit     rl, exp_sat;
      longint bias, acc, sum, exp_data;
      cfg_p = ($urandom_range(0, 9) == 0) ? $urandom_range(60, 127) : $urandom_range(0, 6);
      eff_p = (cfg_p == 0) ? 1 : (cfg_p > MAX_PASSES) ? MAX_PASSES : cfg_p;
      sh    = $urandom_range(0, 31);
      rl    = 1'($urandom_range(0, 1));
      bias  = longint'($signed($urandom));
      set_cfg(cfg_p, bias, sh, rl);
      acc = bias;
      for (int i = 0; i < eff_p; i++) begin
        sum = longint'({$urandom, $urandom});
        sum = (sum <<< 26) >>> 26;
        if ($urandom_range(0, 1) == 1) sum = sum >>> $urandom_range(0, 30);
        acc += sum;
        if (i > 0) set_cfg($urandom_range(0, 127), longint'($signed($urandom)),
                           $urandom_range(0, 31), 1'($urandom_range(0, 1)));
        repeat ($urandom_range(0, 2)) begin
          @(posedge clk);
          #1;
        end
        do_beat(sum);
      end
      model(acc, sh, rl, exp_data, exp_sat);
      check($sformatf("rnd%0d_valid", p), out_valid, 1);
      check($sformatf("rnd%0d_data", p), out_data, exp_data);
      check($sformatf("rnd%0d_sat", p), out_sat, exp_sat);
      @(posedge clk);
      #1;
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
